adder_subtractor_serial: RTL and testbench

- Parametrised multi-cycle successor of the 8-bit registered adder/subtractor datapath.
- Adds or subtracts two WIDTH-bit two's-complement operands DIGIT bits per clock, using a start/busy/done handshake.
- Registers the result together with carry, overflow, zero and negative flags.
- Sits in the ALU datapath where area matters more than single-cycle latency.

---
 rtl/adder_subtractor_serial_pkg.sv | 26 ++
 rtl/adder_subtractor_serial_digit_slice.sv | 28 ++
 rtl/adder_subtractor_serial.sv | 118 +++++++++++
 tb/tb_adder_subtractor_serial.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/adder_subtractor_serial_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM encoding,
// derived sizes and parameter legality.
package adder_subtractor_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int digit_count(int width, int digit);
    return width / digit;
  endfunction

  // A single-digit configuration still needs a 1-bit counter.
  function automatic int cnt_width(int width, int digit);
    int n;
    n = width / digit;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit params_legal(int width, int digit);
    return (digit > 0) && (width >= 2) && (width % digit == 0);
  endfunction

endpackage

// File: rtl/adder_subtractor_serial_digit_slice.sv
// Combinational DIGIT-bit ripple adder; also exposes the carry into its top
// bit so the top level can form signed overflow on the last digit.
module addsub_digit_slice #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    c_msb_in = c[DIGIT-1];
    cout     = c[DIGIT];
  end

endmodule

// File: rtl/adder_subtractor_serial.sv
// Digit-serial two's-complement adder/subtractor with start/busy/done
// handshake; processes DIGIT bits per clock, LSB digit first.
import adder_subtractor_serial_pkg::*;

module adder_subtractor_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] inbus_a,
  input  logic [WIDTH-1:0] inbus_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] outbus,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic [1:0]       state_dbg
);

  // Handshake: start is accepted on any edge where busy=0 (IDLE or DONE);
  // done is a one-cycle pulse in the cycle after the last digit edge.

  if (!params_legal(WIDTH, DIGIT)) begin : g_bad_params
    $error("adder_subtractor_serial: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  localparam int N  = digit_count(WIDTH, DIGIT);
  localparam int CW = cnt_width(WIDTH, DIGIT);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] op_a, op_b, partial, result_nxt;
  logic             c_reg;
  logic [DIGIT-1:0] dig_a, dig_b, dig_sum;
  logic             dig_cout, dig_c_msb;
  logic             accept, last_digit;
  int unsigned      base;

  assign accept     = start && (state != ST_RUN);
  assign last_digit = (state == ST_RUN) && (cnt == LAST);
  assign base       = 32'(cnt) * DIGIT;
  assign dig_a      = op_a[base +: DIGIT];
  assign dig_b      = op_b[base +: DIGIT];

  addsub_digit_slice #(.DIGIT(DIGIT)) u_slice (
    .a        (dig_a),
    .b        (dig_b),
    .cin      (c_reg),
    .sum      (dig_sum),
    .cout     (dig_cout),
    .c_msb_in (dig_c_msb)
  );

  // Partial result with the current digit merged in; on the last digit this
  // is the complete sum.
  always_comb begin
    result_nxt = partial;
    result_nxt[base +: DIGIT] = dig_sum;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (cnt == LAST) state_nxt = ST_DONE;
      ST_DONE: state_nxt = start ? ST_RUN : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Subtraction is A + ~B with the +1 entering as the initial carry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_a     <= '0;
      op_b     <= '0;
      partial  <= '0;
      c_reg    <= 1'b0;
      cnt      <= '0;
      outbus   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
    end else if (accept) begin
      op_a  <= inbus_a;
      op_b  <= sub ? ~inbus_b : inbus_b;
      c_reg <= sub;
      cnt   <= '0;
    end else if (state == ST_RUN) begin
      partial <= result_nxt;
      c_reg   <= dig_cout;
      cnt     <= cnt + CW'(1);
      if (last_digit) begin
        outbus   <= result_nxt;
        carry    <= dig_cout;
        overflow <= dig_c_msb ^ dig_cout;
        zero     <= (result_nxt == '0);
        negative <= result_nxt[WIDTH-1];
      end
    end
  end

  assign busy      = (state == ST_RUN);
  assign done      = (state == ST_DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_adder_subtractor_serial.sv
// Directed bench for adder_subtractor_serial (WIDTH=8, DIGIT=2): driver tasks
// push hand-computed results; a done-triggered monitor pops and compares.
module tb_adder_subtractor_serial;

  localparam int W = 8;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         sub;
  logic [W-1:0] inbus_a, inbus_b;
  logic         busy, done, carry, overflow, zero, negative;
  logic [W-1:0] outbus;
  logic [1:0]   state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  int done_seen = 0;
  logic [W+3:0] exp_q[$];
  logic [W+3:0] exp_e;

  adder_subtractor_serial #(.WIDTH(W), .DIGIT(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .sub       (sub),
    .inbus_a   (inbus_a),
    .inbus_b   (inbus_b),
    .busy      (busy),
    .done      (done),
    .outbus    (outbus),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
  endtask

  // Scoreboard monitor: expected word is {outbus, carry, overflow, zero, negative}
  always @(negedge clk) begin
    if (reset === 1'b1 && done === 1'b1) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: got done with empty queue, outbus=0x%0h", outbus);
      end else begin
        exp_e = exp_q.pop_front();
        check("result_flags", {outbus, carry, overflow, zero, negative}, exp_e);
      end
    end
  end

  // Drivers
  task automatic idle_cycle();
    @(posedge clk); #1;
    check("done_one_cycle", done, 1'b0);
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                        input logic [W+3:0] exp, input bit disturb, input bit chk_hold,
                        input logic [W-1:0] hold_val, input string tag);
    int lat;
    int busy_cyc;
    inbus_a = ta;
    inbus_b = tb_v;
    sub     = ts;
    start   = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    start    = 1'b0;
    lat      = 0;
    busy_cyc = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cyc++;
      if (disturb && lat == 1) begin
        start   = 1'b1;
        inbus_a = ~ta;
        inbus_b = 8'h5A;
        sub     = ~ts;
      end
      if (disturb && lat == 2) start = 1'b0;
      if (chk_hold && lat == 2) check({tag, "_hold"}, outbus, hold_val);
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, 4);
    check({tag, "_busy_cycles"}, busy_cyc, 4);
  endtask

  initial begin
    int seen;
    reset   = 1'b0;
    start   = 1'b0;
    sub     = 1'b0;
    inbus_a = '0;
    inbus_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_outbus", outbus, 8'h00);
    check("rst_flags", {carry, overflow, zero, negative}, 4'b0000);
    check("rst_state", state_dbg, 2'd0);
    reset = 1'b1;
    idle_cycle();

    run_op(8'd100, 8'd27, 1'b0, {8'h7F, 4'b0000}, 0, 0, 8'h00, "add_7f");   idle_cycle();
    run_op(8'd100, 8'd28, 1'b0, {8'h80, 4'b0101}, 0, 0, 8'h00, "add_ovf");  idle_cycle();
    run_op(8'hFF,  8'h01, 1'b0, {8'h00, 4'b1010}, 0, 0, 8'h00, "add_wrap"); idle_cycle();
    run_op(8'd5,   8'd5,  1'b1, {8'h00, 4'b1010}, 0, 0, 8'h00, "sub_zero"); idle_cycle();
    run_op(8'd3,   8'd5,  1'b1, {8'hFE, 4'b0001}, 0, 0, 8'h00, "sub_neg");  idle_cycle();
    run_op(8'h00,  8'h80, 1'b1, {8'h80, 4'b0101}, 0, 0, 8'h00, "sub_min");  idle_cycle();
    run_op(8'h12,  8'h34, 1'b0, {8'h46, 4'b0000}, 1, 0, 8'h00, "disturb");  idle_cycle();

    // Back-to-back: second start issued in the DONE cycle of the first
    run_op(8'h10,  8'h20, 1'b0, {8'h30, 4'b0000}, 0, 0, 8'h00, "b2b_first");
    run_op(8'h50,  8'h60, 1'b1, {8'hF0, 4'b0001}, 0, 1, 8'h30, "b2b_second");
    idle_cycle();

    // Asynchronous reset after two digits of an operation
    inbus_a = 8'h11;
    inbus_b = 8'h22;
    sub     = 1'b0;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_outbus", outbus, 8'h00);
    check("abort_flags", {carry, overflow, zero, negative}, 4'b0000);
    check("abort_state", state_dbg, 2'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    seen  = done_seen;
    repeat (8) @(posedge clk);
    #1;
    check("abort_no_done", done_seen, seen);

    run_op(8'h7F, 8'h01, 1'b0, {8'h80, 4'b0101}, 0, 0, 8'h00, "post_reset");
    idle_cycle();
    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
